// File: rtl/soc_pkg.sv
// Shared SoC definitions: opcode constants, dispatch path enum, FSM state
// type and the opcode classifier used by dispatch and the downstream merge.
package soc_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IOP  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_U    = 7'b0110111;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_J    = 7'b1101111;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_NOP  = 7'b0000000;

  localparam int NUM_PATHS = 3;

  typedef enum logic [1:0] {
    PATH_BR  = 2'd0,
    PATH_ST  = 2'd1,
    PATH_ALU = 2'd2,
    PATH_ILL = 2'd3
  } path_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    ACK_UP  = 2'd3
  } state_e;

  // Map an opcode to the execution path that owns it.
  function automatic path_e classify(input logic [6:0] op);
    path_e p;
    case (op)
      OP_B, OP_J:                          p = PATH_BR;
      OP_S:                                p = PATH_ST;
      OP_R, OP_IOP, OP_LOAD, OP_U, OP_NOP: p = PATH_ALU;
      default:                             p = PATH_ILL;
    endcase
    return p;
  endfunction

  // One-hot request/ack lane for a path; bit 0 is path 1. Illegal gives 0.
  function automatic logic [NUM_PATHS-1:0] path_onehot(input path_e p);
    logic [NUM_PATHS-1:0] v;
    case (p)
      PATH_BR:  v = 3'b001;
      PATH_ST:  v = 3'b010;
      PATH_ALU: v = 3'b100;
      default:  v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/dispatch_3.sv
// Single-entry instruction dispatcher: takes one instruction over a 4-phase
// handshake, routes it to the branch, store or ALU path over a second 4-phase
// handshake, then completes the upstream handshake. Every output is a flop.
module dispatch_3
  import soc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_req,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ack,
  output logic              out_req_1,
  output logic              out_req_2,
  output logic              out_req_3,
  input  logic              ack_in_1,
  input  logic              ack_in_2,
  input  logic              ack_in_3,
  output logic [DATA_W-1:0] out_data,
  output logic              illegal,
  output logic [CNT_W-1:0]  issue_cnt
);

  state_e                 r_state, w_state;
  path_e                  r_path,  w_path;
  logic [DATA_W-1:0]      r_data,  w_data;
  logic [NUM_PATHS-1:0]   r_req,   w_req;
  logic                   r_ack,   w_ack;
  logic                   r_ill,   w_ill;
  logic [CNT_W-1:0]       r_cnt,   w_cnt;

  path_e                  w_in_path;
  logic [NUM_PATHS-1:0]   w_acks;
  logic                   w_sel_ack;

  // Only the ack of the captured path is ever looked at; others are masked.
  assign w_acks    = {ack_in_3, ack_in_2, ack_in_1};
  assign w_sel_ack = |(path_onehot(r_path) & w_acks);
  assign w_in_path = classify(in_data[6:0]);

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    w_state = r_state;
    w_path  = r_path;
    w_data  = r_data;
    w_req   = r_req;
    w_ack   = r_ack;
    w_ill   = r_ill;
    w_cnt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (in_req) begin
          w_data = in_data;
          w_path = w_in_path;
          if (w_in_path == PATH_ILL) begin
            // Nothing downstream; drain upstream straight away.
            w_ill   = 1'b1;
            w_ack   = 1'b1;
            w_state = ACK_UP;
          end else begin
            w_req   = path_onehot(w_in_path);
            w_state = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (w_sel_ack) begin
          w_req   = '0;
          w_state = RELEASE;
        end
      end
      RELEASE: begin
        if (!w_sel_ack) begin
          w_ack   = 1'b1;
          w_cnt   = r_cnt + CNT_W'(1);
          w_state = ACK_UP;
        end
      end
      ACK_UP: begin
        if (!in_req) begin
          w_ack   = 1'b0;
          w_state = IDLE;
        end
      end
      default: begin
        w_req   = '0;
        w_ack   = 1'b0;
        w_state = IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_path  <= PATH_ILL;
      r_data  <= '0;
      r_req   <= '0;
      r_ack   <= 1'b0;
      r_ill   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_path  <= w_path;
      r_data  <= w_data;
      r_req   <= w_req;
      r_ack   <= w_ack;
      r_ill   <= w_ill;
      r_cnt   <= w_cnt;
    end
  end

  assign in_ack    = r_ack;
  assign out_req_1 = r_req[0];
  assign out_req_2 = r_req[1];
  assign out_req_3 = r_req[2];
  assign out_data  = r_data;
  assign illegal   = r_ill;
  assign issue_cnt = r_cnt;

endmodule

// File: tb/tb_dispatch_3.sv
// Randomized self-checking bench for dispatch_3. A transaction-level model
// (path table, expected counter, sticky illegal bit) predicts every output.
// The counter is built 8 bits wide so the wrap case stays short.
module tb_dispatch_3;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_req = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              ack1 = 1'b0, ack2 = 1'b0, ack3 = 1'b0;
  logic              in_ack, o1, o2, o3, illegal;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  issue_cnt;
  logic [2:0]        reqs;

  int checks = 0;
  int failures = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic             exp_ill = 1'b0;

  always #5 clk = ~clk;

  dispatch_3 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_req(in_req), .in_data(in_data), .in_ack(in_ack),
    .out_req_1(o1), .out_req_2(o2), .out_req_3(o3),
    .ack_in_1(ack1), .ack_in_2(ack2), .ack_in_3(ack3),
    .out_data(out_data), .illegal(illegal), .issue_cnt(issue_cnt)
  );

  assign reqs = {o3, o2, o1};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Never more than one downstream request, outside of reset.
  always @(negedge clk) if (!rst) chk("onehot", 64'($countones(reqs) <= 1), 64'd1);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference path table: 1 branch/jump, 2 store, 3 ALU/load/NOP, 0 illegal.
  function automatic int ref_path(input logic [6:0] op);
    case (op)
      7'h63, 7'h6F:                      return 1;
      7'h23:                             return 2;
      7'h33, 7'h13, 7'h03, 7'h37, 7'h00: return 3;
      default:                           return 0;
    endcase
  endfunction

  function automatic logic [2:0] ref_vec(input int k);
    logic [2:0] v = 3'b000;
    if (k > 0) v[k-1] = 1'b1;
    return v;
  endfunction

  task automatic set_ack(input int k, input logic v);
    case (k)
      1: ack1 = v;
      2: ack2 = v;
      3: ack3 = v;
      default: ;
    endcase
  endtask

  // Hold path k in ISSUE for dly cycles (optionally with noise on the other
  // acks), then acknowledge and expect the request to drop.
  task automatic ack_phase(input int k, input logic [31:0] d, input int dly, input bit spur);
    repeat (dly) begin
      if (spur) begin
        for (int j = 1; j <= 3; j++) if (j != k) set_ack(j, 1'($urandom_range(0, 1)));
      end
      tick;
      chk("iss_req", reqs, ref_vec(k));
      chk("iss_ack", in_ack, 1'b0);
      chk("iss_data", out_data, d);
      chk("iss_cnt", issue_cnt, exp_cnt);
    end
    for (int j = 1; j <= 3; j++) set_ack(j, 1'b0);
    set_ack(k, 1'b1);
    tick;
    chk("ack_drop_req", reqs, 3'b000);
    chk("ack_in_ack", in_ack, 1'b0);
  endtask

  task automatic txn(input logic [31:0] d, input int ack_dly, input int rel_dly,
                     input int hold, input bit spur, input bit rst_mid);
    int k = ref_path(d[6:0]);
    in_data = d;
    in_req  = 1'b1;
    tick;
    if (k == 0) exp_ill = 1'b1;
    chk("cap_req", reqs, ref_vec(k));
    chk("cap_data", out_data, d);
    chk("cap_ack", in_ack, 64'(k == 0));
    chk("cap_ill", illegal, exp_ill);
    in_data = $urandom();
    if (k != 0) begin
      ack_phase(k, d, ack_dly, spur);
      if (rst_mid) begin
        rst = 1'b1;
        set_ack(k, 1'b0);
        tick;
        chk("rst_reqs", reqs, 3'b000);
        chk("rst_ack", in_ack, 1'b0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_ill", illegal, 1'b0);
        chk("rst_cnt", issue_cnt, 0);
        exp_cnt = '0;
        exp_ill = 1'b0;
        rst = 1'b0;
        in_data = d;
        tick;
        chk("recap_req", reqs, ref_vec(k));
        chk("recap_data", out_data, d);
        in_data = $urandom();
        ack_phase(k, d, ack_dly, spur);
      end
      repeat (rel_dly) begin
        tick;
        chk("rel_ack", in_ack, 1'b0);
        chk("rel_req", reqs, 3'b000);
        chk("rel_cnt", issue_cnt, exp_cnt);
      end
      set_ack(k, 1'b0);
      tick;
      exp_cnt++;
      chk("up_ack", in_ack, 1'b1);
      chk("up_cnt", issue_cnt, exp_cnt);
      chk("up_data", out_data, d);
    end
    repeat (hold) begin
      in_data = $urandom();
      tick;
      chk("hold_ack", in_ack, 1'b1);
      chk("hold_req", reqs, 3'b000);
      chk("hold_data", out_data, d);
    end
    in_req = 1'b0;
    tick;
    chk("end_ack", in_ack, 1'b0);
    chk("end_cnt", issue_cnt, exp_cnt);
    chk("end_ill", illegal, exp_ill);
  endtask

  logic [6:0] legal_ops [8] = '{7'h63, 7'h6F, 7'h23, 7'h33, 7'h13, 7'h03, 7'h37, 7'h00};

  initial begin
    logic [31:0] d;
    // Reset state
    rst = 1'b1;
    repeat (3) tick;
    chk("rst0_reqs", reqs, 3'b000);
    chk("rst0_ack", in_ack, 1'b0);
    chk("rst0_ill", illegal, 1'b0);
    chk("rst0_cnt", issue_cnt, 0);
    chk("rst0_data", out_data, 32'h0);
    rst = 1'b0;

    // Acks while idle do nothing
    ack1 = 1'b1; ack2 = 1'b1; ack3 = 1'b1;
    tick;
    ack1 = 1'b0; ack2 = 1'b0; ack3 = 1'b0;
    tick;
    chk("idle_ack_req", reqs, 3'b000);
    chk("idle_ack_ack", in_ack, 1'b0);
    chk("idle_ack_cnt", issue_cnt, 0);

    // BEQ, ack two cycles after the request
    txn(32'h00A28263, 2, 1, 1, 1'b0, 1'b0);
    chk("beq_cnt", issue_cnt, 1);
    // Store then ADD back to back, spurious acks during the ADD issue
    txn(32'h00512023, 1, 0, 0, 1'b0, 1'b0);
    txn(32'h005302B3, 4, 2, 0, 1'b1, 1'b0);
    chk("pair_cnt", issue_cnt, 3);
    // Illegal opcode, then a legal one: flag stays set
    txn(32'h0000007F, 0, 0, 2, 1'b0, 1'b0);
    txn(32'h00000013, 1, 1, 0, 1'b0, 1'b0);
    chk("ill_sticky", illegal, 1'b1);
    // Reset in RELEASE with in_req held, then re-capture
    txn(32'h00000037, 1, 2, 0, 1'b0, 1'b1);
    chk("post_rst_cnt", issue_cnt, 1);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      d = $urandom();
      if ($urandom_range(0, 9) < 7) d[6:0] = legal_ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0) begin
        ack1 = 1'($urandom_range(0, 1));
        ack2 = 1'($urandom_range(0, 1));
        ack3 = 1'($urandom_range(0, 1));
        tick;
        ack1 = 1'b0; ack2 = 1'b0; ack3 = 1'b0;
        chk("rnd_idle_req", reqs, 3'b000);
      end
      txn(d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
          1'($urandom_range(0, 1)), 1'b0);
    end

    // Counter wrap: fill to all-ones with NOPs, one more wraps to zero
    while (exp_cnt != {CNT_W{1'b1}}) txn(32'h0, 0, 0, 0, 1'b0, 1'b0);
    chk("full_cnt", issue_cnt, {CNT_W{1'b1}});
    txn(32'h0, 0, 0, 0, 1'b0, 1'b0);
    chk("wrap_cnt", issue_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dispatch_3.md
DISPATCH_3 -- requirements
Module: dispatch_3

Interface
REQ-001 Parameter: DATA_W, default 32, instruction word width; opcode = in_data[6:0].
REQ-002 Parameter: CNT_W, default 16, width of the issue counter.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_req  input  1  upstream 4-phase request; in_data valid while high.
REQ-006 in_data  input  DATA_W  instruction word from decode.
REQ-007 in_ack  output  1  upstream 4-phase acknowledge.
REQ-008 out_req_1  output  1  request to branch/jump path.
REQ-009 out_req_2  output  1  request to store path.
REQ-010 out_req_3  output  1  request to ALU/load/NOP path.
REQ-011 ack_in_1, ack_in_2, ack_in_3  input  1 each  acknowledges from the matching paths.
REQ-012 out_data  output  DATA_W  captured instruction, stable from capture until return to IDLE.
REQ-013 illegal  output  1  sticky flag: an unsupported opcode was received.
REQ-014 issue_cnt  output  CNT_W  count of completed legal dispatches.

Function
REQ-015 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-016 Opcode classes: 1100011 (B) and 1101111 (J) map to path 1.
REQ-017 Opcode class: 0100011 (S) maps to path 2.
REQ-018 Opcode classes: 0110011 (R), 0010011 (I-op), 0000011 (load), 0110111 (U) and 0000000 (NOP) map to path 3.
REQ-019 Any other opcode is illegal.
REQ-020 FSM states: IDLE, ISSUE, RELEASE, ACK_UP.
REQ-021 IDLE: on in_req=1 at an edge, capture in_data into out_data and the path index; go to ISSUE if legal, else go to ACK_UP and set illegal.
REQ-022 ISSUE: out_req_k=1 for the selected path k only, from the cycle after capture (1-cycle latency); when ack_in_k=1 is sampled, drop out_req_k next cycle and go to RELEASE.
REQ-023 RELEASE: wait for ack_in_k=0; then set in_ack=1, increment issue_cnt, go to ACK_UP.
REQ-024 ACK_UP: hold in_ack=1 until in_req=0 is sampled; then set in_ack=0 and go to IDLE.
REQ-025 Acks on non-selected paths SHALL be ignored in every state; an ack high in IDLE SHALL have no effect.
REQ-026 At most one out_req_x SHALL be high at any time.
REQ-027 Changes to in_data after capture SHALL be ignored until the next IDLE capture.
REQ-028 A new in_req SHALL NOT be accepted until ACK_UP completes (one instruction in flight).
REQ-029 Illegal instruction: no out_req is raised; in_ack is still completed to drain upstream; issue_cnt is unchanged.
REQ-030 illegal stays 1 until reset.
REQ-031 issue_cnt wraps from all-ones to 0 without any flag.

Reset
REQ-032 rst=1 at an edge SHALL force IDLE with in_ack, out_req_1..3, illegal, out_data and issue_cnt all 0, from any state, including mid-handshake.
REQ-033 rst SHALL take priority over all other inputs in the same cycle.
REQ-034 After rst deasserts, a still-high in_req SHALL be treated as a new request.

Structure
REQ-035 Shared package soc_pkg SHALL hold the opcode constants (R, I-op, load, U, B, J, S, NOP).
REQ-036 soc_pkg SHALL also hold the path enum (PATH_BR, PATH_ST, PATH_ALU, PATH_ILL), the classification function, and the FSM state typedef.
REQ-037 No sub-module; classification is a package function used by dispatch_3 and shared with the downstream merge logic.

Verification
REQ-038 Scenario: in_data=0x00A28263 (BEQ), ack_in_1 responds 2 cycles after out_req_1 -> out_req_1 rises 1 cycle after in_req is sampled; in_ack rises after ack_in_1 falls; issue_cnt=1; out_req_2/3 stay 0.
REQ-039 Scenario: back-to-back S (0x00512023) then ADD (0x005302B3) -> out_req_2 handshake, then out_req_3 handshake, never overlapping; issue_cnt=2.
REQ-040 Scenario: opcode 0x7F -> illegal=1, no out_req raised, in_ack completes, issue_cnt unchanged; illegal stays 1 through a following legal instruction.
REQ-041 Scenario: spurious ack_in_2 pulse while path 3 is in ISSUE -> ignored; state, outputs and counter unaffected.
REQ-042 Scenario: rst asserted in RELEASE -> the next cycle has all outputs 0 and state IDLE; a held in_req is re-captured after reset.
REQ-043 Scenario: preload issue_cnt to 0xFFFF via 65535 NOPs and issue one more -> issue_cnt=0x0000.
